seven_seg_bcd_scan: RTL and testbench

//  Multi-digit decimal counter driving a time-multiplexed 7-segment display.

---
 rtl/seven_seg_bcd_scan.sv | 190 +++++++++++++++++++
 tb/tb_seven_seg_bcd_scan.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_bcd_scan.sv
// seven_seg_bcd_scan
//   Multi-digit BCD up/down counter with a rate prescaler, driving a
//   time-multiplexed 7-segment display. The display has leading-zero
//   blanking and selectable output polarity.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   en        count enable; the prescaler only advances while high
//   up        count direction (1 = up), sampled on step cycles only
//   clr       synchronous clear of the count (beats load and step)
//   load      synchronous load of load_val (beats step)
//   load_val  BCD load value, digit k at [4k+3:4k]; digits >9 clamp to 9
//   count     registered BCD count
//   wrap      one-cycle pulse when the count rolls over in either direction
//   seg       {g,f,e,d,c,b,a} of the selected digit, registered
//   an        one-hot digit select, registered
module seven_seg_bcd_scan #(
    parameter int NUM_DIGITS    = 4,
    parameter int COUNT_DIV     = 50000000,
    parameter int SCAN_DIV      = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_ZERO = 7'h3F;
    localparam logic [NUM_DIGITS-1:0] AN_ZERO  = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_RST  = (ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
    localparam logic [NUM_DIGITS-1:0] AN_RST   = (ACTIVE_LOW != 0) ? ~AN_ZERO : AN_ZERO;

    logic [W-1:0]          count_reg, count_next;
    logic [PW-1:0]         presc_reg, presc_next;
    logic                  wrap_reg, wrap_next;
    logic [SW-1:0]         scan_cnt_reg, scan_cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [6:0]            seg_reg, seg_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Per-digit ripple chains. carry/borrow[k] is high when every digit
    // below k is at 9 (up) or 0 (down), so the top bit doubles as the
    // rollover flag. zero_above[k] is high when digits k..N-1 are all 0.
    logic [NUM_DIGITS:0] carry;
    logic [NUM_DIGITS:0] borrow;
    logic [NUM_DIGITS:0] zero_above;
    logic [W-1:0]        inc_val;
    logic [W-1:0]        dec_val;
    logic [W-1:0]        clamp_val;

    assign carry[0]               = 1'b1;
    assign borrow[0]              = 1'b1;
    assign zero_above[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [3:0] lv;
            assign d  = count_reg[4*gi +: 4];
            assign lv = load_val[4*gi +: 4];

            assign inc_val[4*gi +: 4] = !carry[gi]  ? d : ((d >= 4'd9) ? 4'd0 : d + 4'd1);
            assign dec_val[4*gi +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign carry[gi+1]        = carry[gi]  && (d >= 4'd9);
            assign borrow[gi+1]       = borrow[gi] && (d == 4'd0);

            assign clamp_val[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;
            assign zero_above[gi]       = zero_above[gi+1] && (d == 4'd0);
        end
    endgenerate

    // Counter and prescaler.
    logic step;
    assign step = en && (presc_reg == PW'(COUNT_DIV - 1));

    always_comb begin
        count_next = count_reg;
        presc_next = presc_reg;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = '0;
            presc_next = '0;
        end else if (load) begin
            count_next = clamp_val;
            presc_next = '0;
        end else if (en) begin
            if (step) begin
                presc_next = '0;
                count_next = up ? inc_val : dec_val;
                wrap_next  = up ? carry[NUM_DIGITS] : borrow[NUM_DIGITS];
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end
    end

    // Free-running digit scanner.
    always_comb begin
        scan_cnt_next = scan_cnt_reg + SW'(1);
        idx_next      = idx_reg;
        if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_next = '0;
            idx_next      = (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + IW'(1);
        end
    end

    // Output stage: decode the currently selected digit. Blanked digits
    // keep their anode select so every digit gets the same on-time.
    logic [3:0]            sel_digit;
    logic                  sel_blank;
    logic [6:0]            seg_logical;
    logic [NUM_DIGITS-1:0] an_logical;

    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_reg == IW'(k)) begin
                sel_digit = count_reg[4*k +: 4];
                sel_blank = (k != 0) && zero_above[k];
            end
        end
        seg_logical = decode(sel_digit);
        if ((BLANK_LEADING != 0) && sel_blank) begin
            seg_logical = 7'h00;
        end
        an_logical = AN_ZERO << idx_reg;
        seg_next   = (ACTIVE_LOW != 0) ? ~seg_logical : seg_logical;
        an_next    = (ACTIVE_LOW != 0) ? ~an_logical  : an_logical;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            presc_reg    <= '0;
            wrap_reg     <= 1'b0;
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            seg_reg      <= SEG_RST;
            an_reg       <= AN_RST;
        end else begin
            count_reg    <= count_next;
            presc_reg    <= presc_next;
            wrap_reg     <= wrap_next;
            scan_cnt_reg <= scan_cnt_next;
            idx_reg      <= idx_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;
    assign seg   = seg_reg;
    assign an    = an_reg;

endmodule

// File: tb/tb_seven_seg_bcd_scan.sv
// Testbench for seven_seg_bcd_scan.
//   dut_a: 4 digits, COUNT_DIV=1, SCAN_DIV=4, active-high, blanking on.
//   dut_b: 4 digits, COUNT_DIV=5, SCAN_DIV=4, active-low, blanking on.
module tb_seven_seg_bcd_scan;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic        rst, en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  an;

    // dut_b signals
    logic        rst_b, en_b, up_b, clr_b, load_b;
    logic [15:0] load_val_b;
    logic [15:0] count_b;
    logic        wrap_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    seven_seg_bcd_scan #(
        .NUM_DIGITS(4), .COUNT_DIV(1), .SCAN_DIV(4), .ACTIVE_LOW(0), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count), .wrap(wrap), .seg(seg), .an(an)
    );

    seven_seg_bcd_scan #(
        .NUM_DIGITS(4), .COUNT_DIV(5), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .clr(clr_b), .load(load_b),
        .load_val(load_val_b), .count(count_b), .wrap(wrap_b), .seg(seg_b), .an(an_b)
    );

    typedef struct {
        string       name;
        logic        clr;
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] lv;
        logic [15:0] exp_count;
        logic        exp_wrap;
    } vec_t;

    typedef struct {
        string       name;
        logic        use_b;
        logic [15:0] cnt;
        logic        wrap;
    } exp_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge, then pop the oldest expectation and compare it
    // against whichever DUT it targets.
    task automatic tick_and_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            if (e.use_b) begin
                chk({e.name, "_count"}, 32'(count_b), 32'(e.cnt));
                chk({e.name, "_wrap"}, 32'(wrap_b), 32'(e.wrap));
                $display("txn %s: count_b=%04h wrap_b=%0b", e.name, count_b, wrap_b);
            end else begin
                chk({e.name, "_count"}, 32'(count), 32'(e.cnt));
                chk({e.name, "_wrap"}, 32'(wrap), 32'(e.wrap));
                $display("txn %s: count=%04h wrap=%0b", e.name, count, wrap);
            end
        end
    endtask

    task automatic expect_a(input string name, input logic [15:0] c, input logic w);
        sb.push_back('{name, 1'b0, c, w});
    endtask

    task automatic expect_b(input string name, input logic [15:0] c);
        sb.push_back('{name, 1'b1, c, 1'b0});
    endtask

    // Lock onto the 1000 -> 0001 anode transition, then check 16 cycles of
    // scanning: each digit selected for 4 clocks with the given segments.
    task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] prev;
        logic       found;
        logic [6:0] exp_seg [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        found = 1'b0;
        prev  = an;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk);
            #1;
            if (an == 4'b0001 && prev == 4'b1000) found = 1'b1;
            prev = an;
        end
        chk({tag, "_sync"}, 32'(found), 32'(1));
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                if (i != 0) begin
                    @(posedge clk);
                    #1;
                end
                chk({tag, "_an"}, 32'(an), 32'(4'b0001 << (i / 4)));
                chk({tag, "_seg"}, 32'(seg), 32'(exp_seg[i / 4]));
            end
            $display("txn %s: 16 scan cycles checked", tag);
        end
    endtask

    initial begin
        vecs[0]  = '{"load_0999",     0, 1, 0, 1, 16'h0999, 16'h0999, 0};
        vecs[1]  = '{"carry",         0, 0, 1, 1, 16'h0000, 16'h1000, 0};
        vecs[2]  = '{"load_9999",     0, 1, 1, 1, 16'h9999, 16'h9999, 0};
        vecs[3]  = '{"wrap_up",       0, 0, 1, 1, 16'h0000, 16'h0000, 1};
        vecs[4]  = '{"wrap_pulse_end",0, 0, 0, 1, 16'h0000, 16'h0000, 0};
        vecs[5]  = '{"load_0000",     0, 1, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[6]  = '{"wrap_down",     0, 0, 1, 0, 16'h0000, 16'h9999, 1};
        vecs[7]  = '{"borrow",        0, 0, 1, 0, 16'h0000, 16'h9998, 0};
        vecs[8]  = '{"clamp",         0, 1, 1, 0, 16'hA5F3, 16'h9593, 0};
        vecs[9]  = '{"clr_over_load", 1, 1, 1, 1, 16'h1111, 16'h0000, 0};
        vecs[10] = '{"load_1234",     0, 1, 1, 1, 16'h1234, 16'h1234, 0};
        vecs[11] = '{"step_up",       0, 0, 1, 1, 16'h0000, 16'h1235, 0};
        vecs[12] = '{"step_down",     0, 0, 1, 0, 16'h0000, 16'h1234, 0};

        rst = 1; en = 0; up = 1; clr = 0; load = 0; load_val = '0;
        rst_b = 1; en_b = 0; up_b = 1; clr_b = 0; load_b = 0; load_val_b = '0;

        // Reset for 2 clocks.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_wrap",  32'(wrap),  32'(0));
        chk("rst_an",    32'(an),    32'(4'b0001));
        chk("rst_seg",   32'(seg),   32'(7'h3F));
        chk("rst_b_an",    32'(an_b),    32'(4'b1110));
        chk("rst_b_seg",   32'(seg_b),   32'(7'h40));
        chk("rst_b_count", 32'(count_b), 32'(0));
        rst = 0;

        // Table-driven counter vectors.
        for (int i = 0; i < NV; i++) begin
            clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
            up = vecs[i].up; load_val = vecs[i].lv;
            expect_a(vecs[i].name, vecs[i].exp_count, vecs[i].exp_wrap);
            tick_and_check();
        end
        clr = 0; load = 0;

        // en=0 holds the count.
        en = 0;
        for (int i = 0; i < 10; i++) begin
            expect_a("hold", 16'h1234, 1'b0);
            tick_and_check();
        end

        // Reset in the middle of counting.
        en = 1; up = 1;
        expect_a("run1", 16'h1235, 1'b0); tick_and_check();
        expect_a("run2", 16'h1236, 1'b0); tick_and_check();
        rst = 1;
        expect_a("mid_rst", 16'h0000, 1'b0); tick_and_check();
        chk("mid_rst_an",  32'(an),  32'(4'b0001));
        chk("mid_rst_seg", 32'(seg), 32'(7'h3F));
        rst = 0; en = 0;

        // Scan and blanking with 0042.
        load = 1; load_val = 16'h0042;
        expect_a("load_0042", 16'h0042, 1'b0); tick_and_check();
        load = 0;
        repeat (2) @(posedge clk);
        #1;
        scan_check("scan_0042", 7'h5B, 7'h66, 7'h00, 7'h00);

        // All zeros: only digit 0 lit.
        clr = 1;
        expect_a("clr", 16'h0000, 1'b0); tick_and_check();
        clr = 0;
        repeat (2) @(posedge clk);
        #1;
        scan_check("scan_zero", 7'h3F, 7'h00, 7'h00, 7'h00);

        // dut_b prescaler: one step every 5 enabled clocks.
        rst_b = 0; en_b = 1; up_b = 1;
        for (int n = 1; n <= 12; n++) begin
            expect_b($sformatf("presc_%0d", n), 16'(n / 5));
            tick_and_check();
        end
        // en=0 freezes the prescaler mid-period (it sits at 2 of 5).
        en_b = 0;
        for (int n = 0; n < 3; n++) begin
            expect_b("presc_hold", 16'h0002);
            tick_and_check();
        end
        en_b = 1;
        expect_b("presc_resume1", 16'h0002); tick_and_check();
        expect_b("presc_resume2", 16'h0002); tick_and_check();
        expect_b("presc_resume3", 16'h0003); tick_and_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
